// File: rtl/seg_cursor_game_ctrl_pkg.sv
// Shared constants for the segment-cursor game controller: state codes,
// segment indices, button directions and the small helpers used by the FSM.
package seg_cursor_game_ctrl_pkg;

    localparam logic [1:0] ST_INITIAL = 2'd0;
    localparam logic [1:0] ST_MOVING  = 2'd1;
    localparam logic [1:0] ST_FALLING = 2'd2;
    localparam logic [1:0] ST_WIN     = 2'd3;

    localparam logic [2:0] SEG_A    = 3'd0;
    localparam logic [2:0] SEG_B    = 3'd1;
    localparam logic [2:0] SEG_C    = 3'd2;
    localparam logic [2:0] SEG_D    = 3'd3;
    localparam logic [2:0] SEG_E    = 3'd4;
    localparam logic [2:0] SEG_F    = 3'd5;
    localparam logic [2:0] SEG_G    = 3'd6;
    localparam logic [2:0] SEG_NONE = 3'd7;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [6:0] REC_INIT = 7'b1000000;
    localparam logic [6:0] REC_ALL  = 7'h7F;
    localparam logic [6:0] DISP_OFF = 7'h7F;

    // One-hot mask of a segment; SEG_NONE shifts out to an empty mask.
    function automatic logic [6:0] seg_onehot(input logic [2:0] seg);
        return 7'b0000001 << seg;
    endfunction

    // Where a falling cursor lands next; bottom segments map to themselves
    // because the FSM leaves FALLING instead of moving them.
    function automatic logic [2:0] seg_fall_next(input logic [2:0] seg);
        case (seg)
            SEG_A:   return SEG_G;
            SEG_G:   return SEG_D;
            SEG_B:   return SEG_C;
            SEG_F:   return SEG_E;
            default: return seg;
        endcase
    endfunction

endpackage

// File: rtl/seg_move_table.sv
// Combinational cursor move lookup: (segment, direction) -> target segment.
// Directions with no neighbour return SEG_NONE and valid=0.
module seg_move_table
    import seg_cursor_game_ctrl_pkg::*;
(
    input  logic [2:0] pos,
    input  logic [1:0] dir,
    output logic [2:0] target,
    output logic       valid
);

    // Neighbour table, one inner case per segment.
    always_comb begin
        target = SEG_NONE;
        case (pos)
            SEG_A: case (dir)
                DIR_RIGHT: target = SEG_B;
                DIR_LEFT:  target = SEG_F;
                default:   target = SEG_NONE;
            endcase
            SEG_B: case (dir)
                DIR_LEFT:  target = SEG_A;
                DIR_UP:    target = SEG_A;
                DIR_DOWN:  target = SEG_C;
                default:   target = SEG_NONE;
            endcase
            SEG_C: case (dir)
                DIR_LEFT:  target = SEG_D;
                DIR_UP:    target = SEG_B;
                DIR_DOWN:  target = SEG_D;
                default:   target = SEG_NONE;
            endcase
            SEG_D: case (dir)
                DIR_RIGHT: target = SEG_C;
                DIR_LEFT:  target = SEG_E;
                default:   target = SEG_NONE;
            endcase
            SEG_E: case (dir)
                DIR_RIGHT: target = SEG_D;
                DIR_UP:    target = SEG_F;
                DIR_DOWN:  target = SEG_D;
                default:   target = SEG_NONE;
            endcase
            SEG_F: case (dir)
                DIR_RIGHT: target = SEG_A;
                DIR_UP:    target = SEG_A;
                DIR_DOWN:  target = SEG_E;
                default:   target = SEG_NONE;
            endcase
            SEG_G: case (dir)
                DIR_RIGHT: target = SEG_B;
                DIR_LEFT:  target = SEG_F;
                default:   target = SEG_NONE;
            endcase
            default: target = SEG_NONE;
        endcase
        valid = (target != SEG_NONE);
    end

endmodule

// File: rtl/seg_cursor_game_ctrl.sv
// Segment-cursor game sequencer. Buttons are registered once, the FSM acts
// on the registered copy, and every output is a flop (display is computed
// from next-state values so it lines up with pos/state_out).
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   INITIAL | only G lit, buttons ignored, wait INIT_CYCLES
//   MOVING  | cursor blinks, buttons move it, visited segments lit
//   FALLING | cursor drops one step every FALL_CYCLES, then INITIAL
//   WIN     | whole digit blinks for INIT_CYCLES, then INITIAL
module seg_cursor_game_ctrl
    import seg_cursor_game_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 286,
    parameter int FALL_CYCLES = 48,
    parameter int BLINK_HALF  = 24,
    parameter int CNT_W       = 9
) (
    input  logic       clk_20,
    input  logic       rst,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] digit,
    output logic [6:0] display,
    output logic [2:0] pos,
    output logic [1:0] state_out
);

    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FALL_LAST  = CNT_W'(FALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    logic [3:0]       btn_q;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] blink_cnt, blink_nxt;
    logic             phase, phase_nxt;
    logic [2:0]       pos_nxt;
    logic [6:0]       record, record_nxt;
    logic [6:0]       display_nxt;
    logic [1:0]       dir;
    logic             dir_hit;
    logic [2:0]       move_target;
    logic             move_valid;
    logic [6:0]       cursor_mask;

    assign digit     = 4'b1110;
    assign state_out = state;

    // Pick one direction from the registered buttons: right > left > up > down.
    always_comb begin
        dir_hit = |btn_q;
        if (btn_q[3])      dir = DIR_RIGHT;
        else if (btn_q[2]) dir = DIR_LEFT;
        else if (btn_q[1]) dir = DIR_UP;
        else               dir = DIR_DOWN;
    end

    seg_move_table u_move_table (
        .pos    (pos),
        .dir    (dir),
        .target (move_target),
        .valid  (move_valid)
    );

    // Free-running blink divider; the phase never resets outside rst.
    always_comb begin
        if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
            phase_nxt = ~phase;
        end else begin
            blink_nxt = blink_cnt + CNT_W'(1);
            phase_nxt = phase;
        end
    end

    // Next-state, timer, cursor and visited-record logic.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        pos_nxt    = pos;
        record_nxt = record;
        case (state)
            ST_INITIAL: begin
                if (timer == INIT_LAST) begin
                    state_nxt = ST_MOVING;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_MOVING: begin
                timer_nxt = '0;
                if (dir_hit) begin
                    if (move_valid) begin
                        pos_nxt    = move_target;
                        record_nxt = record | seg_onehot(move_target);
                        if (record_nxt == REC_ALL) state_nxt = ST_WIN;
                    end else begin
                        state_nxt = ST_FALLING;
                    end
                end
            end
            ST_FALLING: begin
                if (timer == FALL_LAST) begin
                    timer_nxt = '0;
                    if (pos == SEG_C || pos == SEG_D || pos == SEG_E) begin
                        state_nxt  = ST_INITIAL;
                        pos_nxt    = SEG_G;
                        record_nxt = REC_INIT;
                    end else begin
                        pos_nxt = seg_fall_next(pos);
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            default: begin
                if (timer == INIT_LAST) begin
                    state_nxt  = ST_INITIAL;
                    timer_nxt  = '0;
                    pos_nxt    = SEG_G;
                    record_nxt = REC_INIT;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
        endcase
    end

    // Segment pattern for the upcoming cycle (active-low).
    always_comb begin
        cursor_mask = seg_onehot(pos_nxt);
        case (state_nxt)
            ST_INITIAL: display_nxt = ~REC_INIT;
            ST_MOVING:  display_nxt = phase_nxt ? (~record_nxt & ~cursor_mask)
                                                : (~record_nxt | cursor_mask);
            ST_FALLING: display_nxt = ~record_nxt & ~cursor_mask;
            default:    display_nxt = phase_nxt ? 7'h00 : DISP_OFF;
        endcase
    end

    // All state and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk_20 or posedge rst) begin
        if (rst) begin
            btn_q     <= '0;
            state     <= ST_INITIAL;
            timer     <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            pos       <= SEG_G;
            record    <= REC_INIT;
            display   <= DISP_OFF;
        end else begin
            btn_q     <= {btn_right, btn_left, btn_up, btn_down};
            state     <= state_nxt;
            timer     <= timer_nxt;
            blink_cnt <= blink_nxt;
            phase     <= phase_nxt;
            pos       <= pos_nxt;
            record    <= record_nxt;
            display   <= display_nxt;
        end
    end

endmodule

// File: tb/tb_seg_cursor_game_ctrl.sv
// Bench for seg_cursor_game_ctrl: a cycle model pushes the expected
// outputs at each rising edge, a checker pops and compares on the falling
// edge, and the directed sequence adds spot checks of the scenario.
module tb_seg_cursor_game_ctrl;

    localparam int IC = 4;
    localparam int FC = 2;
    localparam int BH = 2;

    logic       clk_20 = 1'b0;
    logic       rst = 1'b0;
    logic       btn_right = 1'b0, btn_left = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [3:0] digit;
    logic [6:0] display;
    logic [2:0] pos;
    logic [1:0] state_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];

    // Reference model state; move table rows A..G, columns R/L/U/D, 7 = none.
    int         m_state, m_pos, m_tmr, m_bcnt;
    logic       m_phase;
    logic [6:0] m_rec;
    logic [3:0] m_btn;
    int mv[7][4] = '{'{1,5,7,7}, '{7,0,0,2}, '{7,3,1,3}, '{2,4,7,7},
                     '{3,7,5,3}, '{0,7,0,4}, '{1,5,7,7}};

    seg_cursor_game_ctrl #(
        .INIT_CYCLES (IC),
        .FALL_CYCLES (FC),
        .BLINK_HALF  (BH),
        .CNT_W       (9)
    ) dut (
        .clk_20    (clk_20),
        .rst       (rst),
        .btn_right (btn_right),
        .btn_left  (btn_left),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .digit     (digit),
        .display   (display),
        .pos       (pos),
        .state_out (state_out)
    );

    always #25 clk_20 = ~clk_20;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 6; m_tmr = 0; m_bcnt = 0;
        m_phase = 1'b0; m_rec = 7'b1000000; m_btn = 4'b0000;
        exp_q.delete();
    endtask

    task automatic model_step();
        int         ns, np, nt, dr, tg;
        logic [6:0] nr, d;
        ns = m_state; np = m_pos; nt = m_tmr; nr = m_rec;
        if (m_bcnt == BH - 1) begin
            m_bcnt = 0;
            m_phase = ~m_phase;
        end else begin
            m_bcnt++;
        end
        case (m_state)
            0: if (m_tmr == IC - 1) begin ns = 1; nt = 0; end else nt++;
            1: if (m_btn != 0) begin
                dr = m_btn[3] ? 0 : m_btn[2] ? 1 : m_btn[1] ? 2 : 3;
                tg = mv[m_pos][dr];
                if (tg == 7) begin
                    ns = 2; nt = 0;
                end else begin
                    np = tg; nr[tg] = 1'b1;
                    if (nr == 7'h7F) begin ns = 3; nt = 0; end
                end
            end
            2: if (m_tmr == FC - 1) begin
                nt = 0;
                if (m_pos >= 2 && m_pos <= 4) begin
                    ns = 0; np = 6; nr = 7'b1000000;
                end else begin
                    np = (m_pos == 0) ? 6 : (m_pos == 6) ? 3 : (m_pos == 1) ? 2 : 4;
                end
            end else nt++;
            default: if (m_tmr == IC - 1) begin
                ns = 0; np = 6; nr = 7'b1000000; nt = 0;
            end else nt++;
        endcase
        m_state = ns; m_pos = np; m_tmr = nt; m_rec = nr;
        m_btn = {btn_right, btn_left, btn_up, btn_down};
        case (m_state)
            0: d = 7'b0111111;
            1: begin d = ~m_rec; d[m_pos] = ~m_phase; end
            2: begin d = ~m_rec; d[m_pos] = 1'b0; end
            default: d = m_phase ? 7'h00 : 7'h7F;
        endcase
        exp_q.push_back({2'(m_state), 3'(m_pos), d});
    endtask

    // Model advances on the same edge as the DUT.
    always @(posedge clk_20) if (!rst) model_step();

    // Scoreboard compare half a cycle after each edge.
    always @(negedge clk_20) begin
        logic [11:0] e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_state", int'(state_out), int'(e[11:10]));
            chk("sb_pos", int'(pos), int'(e[9:7]));
            chk("sb_display", int'(display), int'(e[6:0]));
            chk("sb_digit", int'(digit), 'hE);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_20);
    endtask

    task automatic pulse(input logic r, input logic l, input logic u, input logic d);
        btn_right = r; btn_left = l; btn_up = u; btn_down = d;
        @(negedge clk_20);
        btn_right = 1'b0; btn_left = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        @(negedge clk_20);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_display"}, int'(display), 'h7F);
        chk({tag, "_state"}, int'(state_out), 0);
        chk({tag, "_pos"}, int'(pos), 6);
        chk({tag, "_digit"}, int'(digit), 'hE);
    endtask

    task automatic async_reset(input string tag);
        #5;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_vals(tag);
        model_reset();
        @(negedge clk_20);
        chk({tag, "_held"}, int'(display), 'h7F);
        @(negedge clk_20);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_vals("por");
        model_reset();
        repeat (2) @(negedge clk_20);
        rst = 1'b0;

        idle(3);
        chk("init_state", int'(state_out), 0);
        chk("init_display", int'(display), 'h3F);
        idle(1);
        chk("init_to_moving", int'(state_out), 1);
        chk("moving_pos", int'(pos), 6);

        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("left_to_f", int'(pos), 5);
        idle(3);

        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("right_wins", int'(pos), 0);

        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("fall_state", int'(state_out), 2);
        chk("fall_pos_a", int'(pos), 0);
        idle(2);
        chk("fall_pos_g", int'(pos), 6);
        idle(2);
        chk("fall_pos_d", int'(pos), 3);
        idle(2);
        chk("fall_done_state", int'(state_out), 0);
        chk("fall_done_pos", int'(pos), 6);
        chk("fall_done_display", int'(display), 'h3F);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("init_ignores_btn", int'(pos), 6);
        idle(2);
        chk("moving_again", int'(state_out), 1);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tour_not_won", int'(state_out), 1);
        chk("tour_at_f", int'(pos), 5);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("win_state", int'(state_out), 3);
        chk("win_pos", int'(pos), 0);
        idle(3);
        chk("win_hold", int'(state_out), 3);
        idle(1);
        chk("win_exit_state", int'(state_out), 0);
        chk("win_exit_pos", int'(pos), 6);

        idle(4);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("g_up_falls", int'(state_out), 2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("fall_ignores_btn", int'(pos), 3);
        async_reset("rst_falling");
        idle(4);
        chk("after_rst_moving", int'(state_out), 1);

        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("win2_state", int'(state_out), 3);
        idle(1);
        async_reset("rst_win");
        idle(4);
        chk("after_rst2_moving", int'(state_out), 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
